// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions: widths, register-index width and the MEM-stage
// state encoding.
package mem_access_stage_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 8;
    localparam int REG_IDX_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_OUT     = 2'd3
    } mem_state_t;

    function automatic logic word_aligned(input logic [1:0] byte_lsb);
        return byte_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM input handshake and MEM/WB output handshake of the memory-access stage.
interface mem_access_stage_if
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_alu_res;
    logic [DATA_W-1:0]    in_store_data;
    logic                 in_mem_read;
    logic                 in_mem_write;
    logic [REG_IDX_W-1:0] in_rd;
    logic                 in_reg_write;

    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_result;
    logic [REG_IDX_W-1:0] out_rd;
    logic                 out_reg_write;
    logic                 out_err;

    modport master (
        output in_valid, in_alu_res, in_store_data, in_mem_read, in_mem_write,
               in_rd, in_reg_write, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_reg_write, out_err
    );

    modport slave (
        input  in_valid, in_alu_res, in_store_data, in_mem_read, in_mem_write,
               in_rd, in_reg_write, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_reg_write, out_err
    );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB payload register with load enable; clear wins over load.
module mem_wb_reg
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 le,
    input  logic [DATA_W-1:0]    d_result,
    input  logic [REG_IDX_W-1:0] d_rd,
    input  logic                 d_reg_write,
    input  logic                 d_err,
    output logic [DATA_W-1:0]    q_result,
    output logic [REG_IDX_W-1:0] q_rd,
    output logic                 q_reg_write,
    output logic                 q_err
);
    always_ff @(posedge clk) begin
        if (clr) begin
            q_result    <= '0;
            q_rd        <= '0;
            q_reg_write <= 1'b0;
            q_err       <= 1'b0;
        end else if (le) begin
            q_result    <= d_result;
            q_rd        <= d_rd;
            q_reg_write <= d_reg_write;
            q_err       <= d_err;
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: one word access per instruction on a tri-state bus,
// result handed to WB through a valid/ready handshake.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_stage_if.slave pipe,
    output logic              chipSel,
    output logic [ADDR_W-1:0] addr,
    output logic              write,
    inout  wire  [DATA_W-1:0] dat
);
    mem_state_t           state_reg, state_next;
    logic [ADDR_W-1:0]    addr_reg;
    logic                 is_store_reg;

    logic                 accept, is_mem, bad_op, ld_en;
    logic [DATA_W-1:0]    d_result, q_result;
    logic [REG_IDX_W-1:0] d_rd, q_rd;
    logic                 d_reg_write, q_reg_write;
    logic                 d_err, q_err;

    assign accept = pipe.in_valid && (state_reg == ST_IDLE);
    assign is_mem = pipe.in_mem_read || pipe.in_mem_write;
    assign bad_op = is_mem && (!word_aligned(pipe.in_alu_res[1:0]) ||
                               (pipe.in_mem_read && pipe.in_mem_write));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            is_store_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept && is_mem && !bad_op) begin
                addr_reg     <= pipe.in_alu_res[ADDR_W+1:2];
                is_store_reg <= pipe.in_mem_write;
            end
        end
    end

    // The payload register is loaded at acceptance and, for loads, reloaded
    // with the bus data at the end of CAPTURE; other fields are held then.
    always_comb begin
        state_next  = state_reg;
        ld_en       = 1'b0;
        d_result    = q_result;
        d_rd        = q_rd;
        d_reg_write = q_reg_write;
        d_err       = q_err;
        case (state_reg)
            ST_IDLE: begin
                if (pipe.in_valid) begin
                    ld_en = 1'b1;
                    d_rd  = pipe.in_rd;
                    if (!is_mem) begin
                        d_result    = pipe.in_alu_res;
                        d_reg_write = pipe.in_reg_write;
                        d_err       = 1'b0;
                        state_next  = ST_OUT;
                    end else if (bad_op) begin
                        d_result    = pipe.in_alu_res;
                        d_reg_write = 1'b0;
                        d_err       = 1'b1;
                        state_next  = ST_OUT;
                    end else begin
                        d_result    = pipe.in_mem_write ? pipe.in_store_data : pipe.in_alu_res;
                        d_reg_write = pipe.in_mem_read && pipe.in_reg_write;
                        d_err       = 1'b0;
                        state_next  = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS:  state_next = is_store_reg ? ST_OUT : ST_CAPTURE;
            ST_CAPTURE: begin
                ld_en      = 1'b1;
                d_result   = dat;
                state_next = ST_OUT;
            end
            ST_OUT: begin
                if (pipe.out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    mem_wb_reg #(.DATA_W(DATA_W)) u_mem_wb_reg (
        .clk         (clk),
        .clr         (rst),
        .le          (ld_en),
        .d_result    (d_result),
        .d_rd        (d_rd),
        .d_reg_write (d_reg_write),
        .d_err       (d_err),
        .q_result    (q_result),
        .q_rd        (q_rd),
        .q_reg_write (q_reg_write),
        .q_err       (q_err)
    );

    assign pipe.in_ready      = (state_reg == ST_IDLE);
    assign pipe.out_valid     = (state_reg == ST_OUT);
    assign pipe.out_result    = q_result;
    assign pipe.out_rd        = q_rd;
    assign pipe.out_reg_write = q_reg_write;
    assign pipe.out_err       = q_err;

    // Store data already sits in the payload register, so it drives the bus.
    assign chipSel = (state_reg == ST_ACCESS) || (state_reg == ST_CAPTURE);
    assign write   = (state_reg == ST_ACCESS) && is_store_reg;
    assign addr    = addr_reg;
    assign dat     = write ? q_result : {DATA_W{1'bz}};
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table through a scoreboard, plus
// back-pressure and reset-during-capture sequences.
module tb_mem_access_stage;
    localparam logic [31:0] IDLE_PAT = 32'h5A5A_C3C3;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic        rdf;
        logic        wrf;
        logic [4:0]  rd;
        logic        regw;
        logic [31:0] exp_res;
        logic        exp_err;
        logic        exp_regw;
        int          exp_lat;
        int          exp_cs;
        logic [7:0]  exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        regw;
        logic        err;
        int          lat;
        int          cs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        chipSel, write;
    logic [7:0]  addr;
    wire  [31:0] dat;
    logic [31:0] mem [256];

    int pass_cnt = 0;
    int chk_cnt  = 0;
    exp_t sb[$];
    vec_t vecs[10];

    mem_access_stage_if #(.DATA_W(32)) pipe ();

    mem_access_stage #(.DATA_W(32), .ADDR_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .pipe    (pipe),
        .chipSel (chipSel),
        .addr    (addr),
        .write   (write),
        .dat     (dat)
    );

    always #5 clk = ~clk;

    // Memory model: answers reads while selected, otherwise drives a keeper pattern.
    assign dat = (chipSel && write) ? 32'bz : (chipSel ? mem[addr] : IDLE_PAT);

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= {16'hC0DE, 8'h00, 8'(i)};
        end else if (chipSel && write) begin
            mem[addr] <= dat;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] sdata,
                                input logic rdf, input logic wrf, input logic [4:0] rd,
                                input logic regw, input logic [31:0] exp_res,
                                input logic exp_err, input logic exp_regw,
                                input int lat, input int cs, input logic [7:0] exp_addr);
        vec_t v;
        v.alu = alu; v.sdata = sdata; v.rdf = rdf; v.wrf = wrf; v.rd = rd; v.regw = regw;
        v.exp_res = exp_res; v.exp_err = exp_err; v.exp_regw = exp_regw;
        v.exp_lat = lat; v.exp_cs = cs; v.exp_addr = exp_addr;
        return v;
    endfunction

    task automatic drive_in(input vec_t v);
        pipe.in_valid      = 1'b1;
        pipe.in_alu_res    = v.alu;
        pipe.in_store_data = v.sdata;
        pipe.in_mem_read   = v.rdf;
        pipe.in_mem_write  = v.wrf;
        pipe.in_rd         = v.rd;
        pipe.in_reg_write  = v.regw;
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        exp_t e, got_e;
        int   lat, cs, wr;
        bit   acc, seen, bus_bad;
        @(negedge clk);
        drive_in(v);
        pipe.out_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            if (pipe.in_ready) begin acc = 1; break; end
            @(negedge clk);
        end
        chk("accept", 32'(acc), 32'd1);
        if (!acc) begin pipe.in_valid = 1'b0; return; end
        @(posedge clk);
        e.res = v.exp_res; e.rd = v.rd; e.regw = v.exp_regw; e.err = v.exp_err;
        e.lat = v.exp_lat; e.cs = v.exp_cs;
        sb.push_back(e);
        lat = 1; cs = 0; wr = 0; seen = 0; bus_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            pipe.in_valid = 1'b0;
            if (chipSel) begin
                cs++;
                if (addr !== v.exp_addr) bus_bad = 1;
                if (write) begin
                    wr++;
                    if (dat !== v.sdata) bus_bad = 1;
                end else if (dat !== mem[addr]) bus_bad = 1;
            end else if (write || dat !== IDLE_PAT) bus_bad = 1;
            if (pipe.out_valid) begin seen = 1; break; end
            @(posedge clk);
            lat++;
        end
        chk("out_valid_seen", 32'(seen), 32'd1);
        if (!seen) return;
        got_e = sb.pop_front();
        chk("latency", lat, got_e.lat);
        chk("chipsel_cycles", cs, got_e.cs);
        chk("write_cycles", wr, (got_e.cs == 1) ? 1 : 0);
        chk("bus_drive", 32'(bus_bad), 32'd0);
        if (!got_e.err) chk("out_result", pipe.out_result, got_e.res);
        chk("out_rd", 32'(pipe.out_rd), 32'(got_e.rd));
        chk("out_reg_write", 32'(pipe.out_reg_write), 32'(got_e.regw));
        chk("out_err", 32'(pipe.out_err), 32'(got_e.err));
        chk("in_ready_during_out", 32'(pipe.in_ready), 32'd0);
        $display("txn %0d: alu=%h rd=%0d res=%h err=%b regw=%b lat=%0d cs=%0d",
                 idx, v.alu, pipe.out_rd, pipe.out_result, pipe.out_err,
                 pipe.out_reg_write, lat, cs);
        @(posedge clk);
        @(negedge clk);
        chk("back_to_idle", 32'(pipe.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(32'h1234, 32'h0,         0, 0,  3, 1, 32'h1234,     0, 1, 1, 0, 8'h00);
        vecs[1] = mk(32'h08,   32'hDEADBEEF,  0, 1,  7, 1, 32'hDEADBEEF, 0, 0, 2, 1, 8'h02);
        vecs[2] = mk(32'h08,   32'h0,         1, 0,  5, 1, 32'hDEADBEEF, 0, 1, 3, 2, 8'h02);
        vecs[3] = mk(32'h0A,   32'h0,         1, 0,  6, 1, 32'h0,        1, 0, 1, 0, 8'h00);
        vecs[4] = mk(32'h404,  32'h55AA00FF,  0, 1,  8, 0, 32'h55AA00FF, 0, 0, 2, 1, 8'h01);
        vecs[5] = mk(32'h004,  32'h0,         1, 0,  9, 1, 32'h55AA00FF, 0, 1, 3, 2, 8'h01);
        vecs[6] = mk(32'h10,   32'h1111,      1, 1, 10, 1, 32'h0,        1, 0, 1, 0, 8'h00);
        vecs[7] = mk(32'h3,    32'h0,         0, 0, 31, 0, 32'h3,        0, 0, 1, 0, 8'h00);
        vecs[8] = mk(32'hFFC,  32'h0,         1, 0,  4, 1, 32'hC0DE00FF, 0, 1, 3, 2, 8'hFF);
        vecs[9] = mk(32'h0E,   32'h77,        0, 1,  2, 1, 32'h0,        1, 0, 1, 0, 8'h00);

        rst = 1'b1;
        pipe.in_valid = 1'b0; pipe.in_alu_res = '0; pipe.in_store_data = '0;
        pipe.in_mem_read = 1'b0; pipe.in_mem_write = 1'b0; pipe.in_rd = '0;
        pipe.in_reg_write = 1'b0; pipe.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(pipe.in_ready), 32'd1);
        chk("rst_out_valid", 32'(pipe.out_valid), 32'd0);
        chk("rst_chipsel", 32'(chipSel), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_out_result", pipe.out_result, 32'd0);
        chk("rst_out_rd_regw_err", {27'd0, pipe.out_rd, pipe.out_reg_write, pipe.out_err}, 32'd0);
        chk("rst_dat_z", dat, IDLE_PAT);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) do_txn(i, vecs[i]);

        // Back-pressure: output held for 4 cycles while a second op waits.
        @(negedge clk);
        pipe.out_ready = 1'b0;
        drive_in(mk(32'hABCD, 0, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        drive_in(mk(32'h9999, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0));
        chk("bp_out_valid", 32'(pipe.out_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_stable_result", pipe.out_result, 32'hABCD);
            chk("bp_stable_rd", 32'(pipe.out_rd), 32'd11);
            chk("bp_held_valid_noready", {30'd0, pipe.out_valid, pipe.in_ready}, 32'd2);
        end
        $display("txn bp: held res=%h rd=%0d for 4 cycles", pipe.out_result, pipe.out_rd);
        pipe.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_idle", {30'd0, pipe.out_valid, pipe.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        pipe.in_valid = 1'b0;
        chk("bp_second_result", pipe.out_result, 32'h9999);
        chk("bp_second_rd", 32'(pipe.out_rd), 32'd12);
        $display("txn bp2: res=%h rd=%0d", pipe.out_result, pipe.out_rd);
        @(posedge clk);

        // Reset while a load is in CAPTURE must drop it silently.
        @(negedge clk);
        drive_in(mk(32'h08, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        pipe.in_valid = 1'b0;
        chk("cap_access_cs", {30'd0, chipSel, write}, 32'd2);
        @(posedge clk);
        @(negedge clk);
        chk("cap_capture_cs", {30'd0, chipSel, write}, 32'd2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("cap_rst_idle", 32'(pipe.in_ready), 32'd1);
        chk("cap_rst_chipsel", 32'(chipSel), 32'd0);
        chk("cap_rst_dat_z", dat, IDLE_PAT);
        chk("cap_rst_result", pipe.out_result, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("cap_no_out_valid", 32'(pipe.out_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        $display("txn cap_rst: load aborted, in_ready=%b", pipe.in_ready);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data-path and memory word width.
REQ-002 The block SHALL have parameter ADDR_W, default 8, memory word-address width.
REQ-003 Port clk  in  1: single clock, all state updates on its rising edge.
REQ-004 Port rst  in  1: reset, synchronous and active-high.
REQ-005 Port in_valid  in  1: EX/MEM holds a valid instruction.
REQ-006 Port in_ready  out  1: stage accepts the instruction this cycle.
REQ-007 Port in_alu_res  in  DATA_W: ALU result, which is the byte address for loads and stores.
REQ-008 Port in_store_data  in  DATA_W: store operand.
REQ-009 Port in_mem_read, in_mem_write  in  1 each: load and store flags.
REQ-010 Port in_rd  in  5, and in_reg_write  in  1: destination register and write-back enable.
REQ-011 Port chipSel  out  1, addr  out  ADDR_W, write  out  1, dat  inout  DATA_W: memory bus.
REQ-012 Port out_valid  in/out: out 1, out_ready  in  1: MEM/WB handshake.
REQ-013 Port out_result  out  DATA_W, out_rd  out  5, out_reg_write  out  1, out_err  out  1: MEM/WB payload.

Function
REQ-014 A transfer on either side SHALL occur only when valid and ready are both 1 at a rising edge.
REQ-015 The FSM SHALL have exactly four states: IDLE, ACCESS, CAPTURE, and OUT.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 On acceptance of a non-memory op (read=0, write=0), the FSM SHALL go to OUT with out_result=in_alu_res; latency is 1 cycle.
REQ-018 On acceptance of a memory op with in_alu_res[1:0]!=0, or with both flags set, the FSM SHALL go to OUT with out_err=1, out_reg_write=0, and no bus activity.
REQ-019 On acceptance of a legal load or store, the stage SHALL register addr=in_alu_res[ADDR_W+1:2], and the FSM SHALL go to ACCESS.
REQ-020 In ACCESS, chipSel SHALL be 1; for a store, write=1 and dat SHALL be driven with the store data; for a load, write=0 and dat SHALL be high-Z.
REQ-021 After ACCESS, a store SHALL go to OUT with out_reg_write=0 and out_result=store data; latency is 2 cycles.
REQ-022 After ACCESS, a load SHALL go to CAPTURE, with chipSel=1, write=0, and addr held.
REQ-023 In CAPTURE, the stage SHALL sample dat into out_result at the closing edge, then go to OUT; load latency is 3 cycles.
REQ-024 In every state other than ACCESS-store, the stage SHALL hold dat at high-Z, and write SHALL be 0.
REQ-025 In every state other than ACCESS and CAPTURE, chipSel SHALL be 0.
REQ-026 In OUT, out_valid SHALL be 1 and the payload SHALL be stable until out_ready=1, after which the FSM SHALL return to IDLE.
REQ-027 There SHALL be no same-cycle OUT-to-accept bypass, so the sustained maximum throughput is one instruction per 2 cycles.
REQ-028 out_rd SHALL equal in_rd of the accepted instruction, and out_reg_write SHALL equal in_reg_write except where REQ-018 or REQ-021 forces it to 0.
REQ-029 Address bits above ADDR_W+1 SHALL be ignored, and addresses SHALL wrap modulo 2^ADDR_W words.

Reset
REQ-030 While rst=1 at a rising edge, the FSM SHALL go to IDLE, and out_valid, chipSel, write, out_err, and out_reg_write SHALL be 0; out_result, addr, and out_rd SHALL be 0; dat SHALL be high-Z.
REQ-031 A reset asserted in ACCESS or CAPTURE SHALL abort the access at that edge, and the dropped instruction SHALL never produce out_valid.
REQ-032 rst SHALL take priority over all handshakes in the same cycle.

Structure
REQ-033 The FSM state encoding, DATA_W, ADDR_W, and the register-index width (5) SHALL live in a shared package used by all pipeline stages.
REQ-034 The payload output register SHALL be one sub-module, mem_wb_reg, with load-enable and synchronous clear.

Verification
REQ-035 Reset, then add-type op with alu_res=0x1234 and rd=3 -> out_valid 1 cycle later, out_result=0x1234, out_rd=3, chipSel never 1.
REQ-036 Store of 0xDEADBEEF at alu_res=0x08 -> chipSel=1, write=1, addr=2, and dat=0xDEADBEEF for exactly one cycle; out_valid 2 cycles after accept.
REQ-037 Then load from 0x08 with rd=5 -> chipSel high for 2 cycles, write=0, out_result=0xDEADBEEF at 3 cycles, out_reg_write=1.
REQ-038 Load from alu_res=0x0A -> out_err=1, out_reg_write=0, chipSel stays 0.
REQ-039 Hold out_ready=0 for 4 cycles after out_valid -> payload stable, in_ready=0 throughout, new in_valid not accepted.
REQ-040 Assert rst during CAPTURE of a load -> next cycle FSM in IDLE, chipSel=0, dat high-Z, and no out_valid for that load.
